uart_rx_seq: RTL and testbench

- Serial-receive sequencer that sits directly upstream of the 8-bit shift register.
- It oversamples an asynchronous UART-style line (idle high, 1 start bit, 8 data bits, 1 stop bit) and detects frames.
- It drives the shift register's D, mode and parallel-load inputs so the received byte assembles in that register's parallel output.
- It flags frame completion and frame errors to the consumer.

---
 rtl/uart_rx_seq.sv | 118 +++++++++++
 tb/tb_uart_rx_seq.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_seq.sv
// Serial-receive sequencer: oversamples a UART line (8N1) and steers a downstream
// 8-bit shift register (LOAD to clear, LEFT/RIGHT shifts) so the byte assembles there.
module uart_rx_seq #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       rx_i,
  input  logic       lsb_first_i,
  output logic       D,
  output logic [1:0] mode_o,
  output logic [7:0] par_o,
  output logic       busy_o,
  output logic [3:0] bit_cnt_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);

  localparam logic [1:0] MODE_HOLD  = 2'd0;
  localparam logic [1:0] MODE_LOAD  = 2'd1;
  localparam logic [1:0] MODE_LEFT  = 2'd2;
  localparam logic [1:0] MODE_RIGHT = 2'd3;

  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT/2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             rx_m, rx_s;
  logic             lsb_q;

  assign par_o = 8'h00;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx_i;
      rx_s <= rx_m;
    end
  end

  // Counter restarts at every state entry and after each mid-bit sample, so
  // DATA/STOP samples fall one full bit period after the previous one.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state        <= IDLE;
      cnt          <= '0;
      lsb_q        <= 1'b0;
      D            <= 1'b0;
      mode_o       <= MODE_HOLD;
      busy_o       <= 1'b0;
      bit_cnt_o    <= 4'd0;
      byte_valid_o <= 1'b0;
      frame_err_o  <= 1'b0;
    end else begin
      mode_o       <= MODE_HOLD;
      byte_valid_o <= 1'b0;
      frame_err_o  <= 1'b0;
      case (state)
        IDLE: begin
          busy_o    <= 1'b0;
          bit_cnt_o <= 4'd0;
          cnt       <= '0;
          if (!rx_s) state <= START;
        end
        START: begin
          if (cnt == HALF_M1) begin
            cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
            end else begin
              state     <= DATA;
              mode_o    <= MODE_LOAD;
              lsb_q     <= lsb_first_i;
              busy_o    <= 1'b1;
              bit_cnt_o <= 4'd0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == FULL_M1) begin
            cnt       <= '0;
            D         <= rx_s;
            mode_o    <= lsb_q ? MODE_RIGHT : MODE_LEFT;
            bit_cnt_o <= bit_cnt_o + 4'd1;
            if (bit_cnt_o == 4'd7) state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == FULL_M1) begin
            cnt          <= '0;
            byte_valid_o <= 1'b1;
            frame_err_o  <= ~rx_s;
            state        <= rx_s ? IDLE : BRK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BRK: begin
          // A held-low line is a break, not a new start bit.
          cnt <= '0;
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_seq.sv
// Bench for uart_rx_seq: line waveforms are built per phase, a frame-level parser
// predicts per-cycle outputs, and a shift-register model checks the assembled bytes.
module tb_uart_rx_seq;
  localparam int CPB  = 8;
  localparam int H    = CPB / 2;
  localparam int MAXW = 1024;

  logic       tb_clk = 1'b0;
  logic       nrst;
  logic       rx_i;
  logic       lsb_first_i;
  logic       d;
  logic [1:0] mode_o;
  logic [7:0] par_o;
  logic       busy_o;
  logic [3:0] bit_cnt_o;
  logic       byte_valid_o;
  logic       frame_err_o;

  uart_rx_seq #(.CLKS_PER_BIT(CPB), .CNT_W(8)) dut (
    .clk(tb_clk), .nrst(nrst), .rx_i(rx_i), .lsb_first_i(lsb_first_i),
    .D(d), .mode_o(mode_o), .par_o(par_o), .busy_o(busy_o),
    .bit_cnt_o(bit_cnt_o), .byte_valid_o(byte_valid_o), .frame_err_o(frame_err_o)
  );

  always #5 tb_clk = ~tb_clk;

  // Downstream shift register the sequencer drives.
  logic [7:0] p;
  always @(posedge tb_clk) begin
    case (mode_o)
      2'd1: p <= par_o;
      2'd2: p <= {p[6:0], d};
      2'd3: p <= {d, p[7:1]};
      default: p <= p;
    endcase
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Waveforms indexed by clock edge n: value present on the pins at posedge n.
  bit wave [MAXW];
  bit lsbw [MAXW];
  int wp;

  logic [1:0] e_mode [MAXW];
  bit         e_d    [MAXW];
  bit         e_busy [MAXW];
  bit         e_bv   [MAXW];
  bit         e_fe   [MAXW];
  int         e_cnt  [MAXW];
  logic [7:0] e_byte [MAXW];
  bit         e_shift[MAXW];
  bit         e_bit  [MAXW];

  task automatic clear_wave();
    wp = 0;
    for (int i = 0; i < MAXW; i++) begin
      wave[i] = 1'b1;
      lsbw[i] = 1'b0;
    end
  endtask

  task automatic add_lvl(input bit v, input int n);
    repeat (n) begin
      wave[wp] = v;
      wp++;
    end
  endtask

  task automatic add_frame(input logic [7:0] b, input bit lsb_first, input bit stop);
    add_lvl(1'b0, CPB);
    for (int k = 0; k < 8; k++) add_lvl(lsb_first ? b[k] : b[7-k], CPB);
    add_lvl(stop, CPB);
  endtask

  task automatic set_lsb(input int from, input bit v);
    for (int i = from; i < MAXW; i++) lsbw[i] = v;
  endtask

  // Frame-level parse of the line as seen through the 2-cycle synchronizer:
  // wave index j is acted on at edge j+2; registered outputs show after that edge.
  task automatic build_model(input int n);
    int j, e0, js, jb, bend, e;
    bit lsb, b;
    logic [7:0] by;
    bit cur;
    for (int i = 0; i < MAXW; i++) begin
      e_mode[i] = 2'd0; e_busy[i] = 1'b0; e_bv[i] = 1'b0; e_fe[i] = 1'b0;
      e_cnt[i] = 0; e_byte[i] = 8'h00; e_shift[i] = 1'b0; e_bit[i] = 1'b0; e_d[i] = 1'b0;
    end
    j = 0;
    while (j < n && j + H + 9*CPB + 3 < MAXW) begin
      if (wave[j]) begin
        j++;
      end else if (wave[j+H]) begin
        j = j + H + 1;
      end else begin
        e0 = j + 2;
        lsb = lsbw[e0+H];
        e_mode[e0+H] = 2'd1;
        by = 8'h00;
        for (int k = 0; k < 8; k++) begin
          js = j + H + CPB*(k+1);
          e  = js + 2;
          b  = wave[js];
          e_shift[e] = 1'b1;
          e_bit[e]   = b;
          e_mode[e]  = lsb ? 2'd3 : 2'd2;
          if (lsb) by[k] = b; else by[7-k] = b;
        end
        js = j + H + 9*CPB;
        e_bv[js+2]   = 1'b1;
        e_fe[js+2]   = ~wave[js];
        e_byte[js+2] = by;
        bend = js + 2;
        jb = js;
        if (!wave[js]) begin
          jb = js + 1;
          while (jb < MAXW - 3 && !wave[jb]) jb++;
          bend = jb + 2;
        end
        for (int ee = e0 + H; ee <= bend && ee < MAXW; ee++) begin
          e_busy[ee] = 1'b1;
          e_cnt[ee]  = ((ee - e0 - H) / CPB > 8) ? 8 : (ee - e0 - H) / CPB;
        end
        j = jb + 1;
      end
    end
    cur = 1'b0;
    for (int i = 0; i < MAXW; i++) begin
      if (e_shift[i]) cur = e_bit[i];
      e_d[i] = cur;
    end
  endtask

  int n_load, n_left, n_right, n_bv;
  bit busy_seen;
  int bv_edge [4];
  logic [7:0] bv_p [4];
  bit bv_fe [4];

  // Drive the phase waveform and compare every cycle against the parsed model.
  task automatic run_phase(input int n);
    build_model(n);
    n_load = 0; n_left = 0; n_right = 0; n_bv = 0; busy_seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      rx_i = wave[i];
      lsb_first_i = lsbw[i];
      @(negedge tb_clk);
      chk($sformatf("mode@%0d", i), mode_o, e_mode[i]);
      chk($sformatf("d@%0d", i), d, e_d[i]);
      chk($sformatf("busy@%0d", i), busy_o, e_busy[i]);
      chk($sformatf("bitcnt@%0d", i), bit_cnt_o, e_cnt[i]);
      chk($sformatf("bv@%0d", i), byte_valid_o, e_bv[i]);
      chk($sformatf("fe@%0d", i), frame_err_o, e_fe[i]);
      if (e_bv[i]) chk($sformatf("byte@%0d", i), p, e_byte[i]);
      if (mode_o == 2'd1) n_load++;
      if (mode_o == 2'd2) n_left++;
      if (mode_o == 2'd3) n_right++;
      busy_seen |= busy_o;
      if (byte_valid_o) begin
        if (n_bv < 4) begin
          bv_edge[n_bv] = i;
          bv_p[n_bv]    = p;
          bv_fe[n_bv]   = frame_err_o;
        end
        n_bv++;
      end
    end
  endtask

  task automatic reset_dut();
    nrst = 1'b0;
    rx_i = 1'b1;
    lsb_first_i = 1'b0;
    repeat (2) @(negedge tb_clk);
    chk("rst_mode", mode_o, 0);
    chk("rst_d", d, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_bitcnt", bit_cnt_o, 0);
    chk("rst_bv", byte_valid_o, 0);
    chk("rst_fe", frame_err_o, 0);
    chk("rst_par", par_o, 0);
    nrst = 1'b1;
  endtask

  initial begin
    nrst = 1'b0;
    rx_i = 1'b1;
    lsb_first_i = 1'b0;

    // Reset in the middle of the data bits.
    reset_dut();
    clear_wave(); add_lvl(1, 5); add_frame(8'h96, 0, 1);
    run_phase(40);
    chk("pre_rst_bitcnt", bit_cnt_o, 3);
    chk("pre_rst_busy", busy_o, 1);
    chk("midrst_bv_count", n_bv, 0);
    nrst = 1'b0;
    #1;
    chk("midrst_mode", mode_o, 0);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_bitcnt", bit_cnt_o, 0);
    chk("midrst_d", d, 0);
    repeat (10) begin
      @(negedge tb_clk);
      chk("midrst_no_bv", byte_valid_o, 0);
    end

    // MSB-first 0xA5.
    reset_dut();
    clear_wave(); add_lvl(1, 3); add_frame(8'hA5, 0, 1); add_lvl(1, 20);
    run_phase(wp);
    chk("a5_loads", n_load, 1);
    chk("a5_lefts", n_left, 8);
    chk("a5_rights", n_right, 0);
    chk("a5_bv_count", n_bv, 1);
    chk("a5_bv_edge", bv_edge[0], 81);
    chk("a5_byte", bv_p[0], 8'hA5);
    chk("a5_fe", bv_fe[0], 0);

    // LSB-first 0x3C.
    reset_dut();
    clear_wave(); set_lsb(0, 1); add_lvl(1, 3); add_frame(8'h3C, 1, 1); add_lvl(1, 20);
    run_phase(wp);
    chk("3c_rights", n_right, 8);
    chk("3c_lefts", n_left, 0);
    chk("3c_bv_count", n_bv, 1);
    chk("3c_byte", bv_p[0], 8'h3C);

    // Two-cycle glitch on an idle line.
    reset_dut();
    clear_wave(); add_lvl(1, 5); add_lvl(0, 2); add_lvl(1, 30);
    run_phase(wp);
    chk("gl_loads", n_load, 0);
    chk("gl_busy_seen", busy_seen, 0);
    chk("gl_bv_count", n_bv, 0);
    chk("gl_p_kept", p, 8'h3C);

    // Low stop bit followed by a held-low line, then a clean frame.
    reset_dut();
    clear_wave(); add_lvl(1, 3); add_frame(8'hC3, 0, 0); add_lvl(0, 40); add_lvl(1, 10);
    add_frame(8'h5A, 0, 1); add_lvl(1, 20);
    run_phase(wp);
    chk("brk_loads", n_load, 2);
    chk("brk_bv_count", n_bv, 2);
    chk("brk_fe0", bv_fe[0], 1);
    chk("brk_byte0", bv_p[0], 8'hC3);
    chk("brk_fe1", bv_fe[1], 0);
    chk("brk_byte1", bv_p[1], 8'h5A);

    // Back-to-back 0x00 then 0xFF; bit order flips mid first frame.
    reset_dut();
    clear_wave(); add_lvl(1, 3); add_frame(8'h00, 0, 1); add_frame(8'hFF, 1, 1); add_lvl(1, 20);
    set_lsb(43, 1);
    run_phase(wp);
    chk("b2b_bv_count", n_bv, 2);
    chk("b2b_spacing", bv_edge[1] - bv_edge[0], 80);
    chk("b2b_byte0", bv_p[0], 8'h00);
    chk("b2b_byte1", bv_p[1], 8'hFF);
    chk("b2b_lefts", n_left, 8);
    chk("b2b_rights", n_right, 8);
    chk("b2b_loads", n_load, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
